// File: rtl/pcmcia_bus_ctrl_pkg.sv
// pcmcia_bus_ctrl_pkg: PCMCIA window map, FSM states and window decode helpers
package pcmcia_bus_ctrl_pkg;
  localparam logic [23:0] COMMON_BASE = 24'h600000;
  localparam logic [23:0] ATTR_BASE   = 24'hA00000;
  localparam logic [23:0] IO_BASE     = 24'hA20000;
  localparam logic [23:0] IO_LIMIT    = 24'hA40000;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ACK} state_t;
  typedef enum logic [1:0] {WIN_NONE, WIN_COMMON, WIN_ATTR, WIN_IO} win_t;

  function automatic win_t win_decode(input logic [23:0] a);
    return (a >= COMMON_BASE && a < ATTR_BASE) ? WIN_COMMON :
           (a >= ATTR_BASE && a < IO_BASE)     ? WIN_ATTR   :
           (a >= IO_BASE && a < IO_LIMIT)      ? WIN_IO     : WIN_NONE;
  endfunction

  // Common memory is rebased to card address 0; attribute and I/O use A[16:0].
  function automatic logic [25:0] card_addr(input logic [23:0] a, input win_t w);
    return (w == WIN_COMMON) ? 26'(a - COMMON_BASE) : {9'd0, a[16:0]};
  endfunction
endpackage

// File: rtl/pcmcia_lane_steer.sv
// pcmcia_lane_steer: big-endian CPU <-> little-endian card byte lanes and CE generation
module pcmcia_lane_steer
  import pcmcia_bus_ctrl_pkg::*;
(
  input  logic        uds,
  input  logic        lds,
  input  logic [15:0] cpu_din,
  input  logic [15:0] cc_din,
  output logic        ce1,
  output logic        ce2,
  output logic        a0,
  output logic [15:0] cc_dout,
  output logic [15:0] rd_data
);
  // Byte accesses always travel on card d[7:0]; the odd byte selects card A0.
  always_comb begin
    ce1     = uds | lds;
    ce2     = uds & lds;
    a0      = lds & ~uds;
    cc_dout = ce2 ? {cpu_din[7:0], cpu_din[15:8]} : uds ? {8'h00, cpu_din[15:8]} : {8'h00, cpu_din[7:0]};
    rd_data = ce2 ? {cc_din[7:0], cc_din[15:8]} : uds ? {cc_din[7:0], 8'hFF} : {8'hFF, cc_din[7:0]};
  end
endmodule

// File: rtl/pcmcia_bus_ctrl.sv
// pcmcia_bus_ctrl: turns single CPU requests in the PCMCIA windows into timed card cycles
module pcmcia_bus_ctrl
  import pcmcia_bus_ctrl_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [22:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_uds,
  input  logic        cpu_lds,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  output logic        busy,
  input  logic        card_present,
  output logic [25:0] cc_addr,
  output logic [15:0] cc_dout,
  input  logic [15:0] cc_din,
  output logic        cc_reg,
  output logic        cc_oe,
  output logic        cc_we,
  output logic        cc_iord,
  output logic        cc_iowr,
  output logic        cc_ce1,
  output logic        cc_ce2,
  input  logic        cc_ireq,
  input  logic        irq_clr,
  output logic        cpu_int
);
  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [25:0] addr_q, addr_d;
  logic [15:0] din_q, din_d, dout_q, dout_d;
  logic        wr_q, wr_d, uds_q, uds_d, lds_q, lds_d, reg_q, reg_d, io_q, io_d;
  logic        ireq_q, ireq_d, int_q, int_d;
  logic        ce1, ce2, a0, active, strobe, hit;
  logic [15:0] steer_dout, steer_rd;
  win_t        win;

  assign win = win_decode({cpu_addr, 1'b0});
  assign hit = (win != WIN_NONE) && card_present && (cpu_uds || cpu_lds);

  pcmcia_lane_steer u_steer (
    .uds     (uds_q),
    .lds     (lds_q),
    .cpu_din (din_q),
    .cc_din  (cc_din),
    .ce1     (ce1),
    .ce2     (ce2),
    .a0      (a0),
    .cc_dout (steer_dout),
    .rd_data (steer_rd)
  );

  // Cycle sequencer: one shared down-counter reloaded on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 8'd1;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    wr_d    = wr_q;
    uds_d   = uds_q;
    lds_d   = lds_q;
    reg_d   = reg_q;
    io_d    = io_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = hit ? SETUP_LD : 8'd0;
        if (cpu_req) begin
          state_d = hit ? S_SETUP : S_ACK;
          addr_d  = card_addr({cpu_addr, 1'b0}, win);
          din_d   = cpu_din;
          dout_d  = hit ? 16'h0000 : 16'hFFFF;
          wr_d    = cpu_wr;
          uds_d   = cpu_uds;
          lds_d   = cpu_lds;
          reg_d   = (win == WIN_ATTR) || (win == WIN_IO);
          io_d    = win == WIN_IO;
        end
      end
      S_SETUP: if (cnt_q == 8'd0) begin
        state_d = S_STROBE;
        cnt_d   = STROBE_LD;
      end
      S_STROBE: if (cnt_q == 8'd0) begin
        state_d = (HOLD_CYC == 0) ? S_ACK : S_HOLD;
        cnt_d   = HOLD_LD;
        dout_d  = wr_q ? 16'h0000 : steer_rd;
      end
      S_HOLD: if (cnt_q == 8'd0) begin
        state_d = S_ACK;
        cnt_d   = 8'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Interrupt latch: a qualified rising edge beats a same-cycle clear; no card clears it.
  always_comb begin
    ireq_d = cc_ireq;
    int_d  = !card_present ? 1'b0 : (cc_ireq && !ireq_q) ? 1'b1 : irq_clr ? 1'b0 : int_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
      uds_q   <= 1'b0;
      lds_q   <= 1'b0;
      reg_q   <= 1'b0;
      io_q    <= 1'b0;
      ireq_q  <= 1'b0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
      uds_q   <= uds_d;
      lds_q   <= lds_d;
      reg_q   <= reg_d;
      io_q    <= io_d;
      ireq_q  <= ireq_d;
      int_q   <= int_d;
    end
  end

  assign active   = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
  assign strobe   = state_q == S_STROBE;
  assign cc_addr  = active ? (addr_q | {25'd0, a0}) : '0;
  assign cc_dout  = (active && wr_q) ? steer_dout : '0;
  assign cc_ce1   = active & ce1;
  assign cc_ce2   = active & ce2;
  assign cc_reg   = active & reg_q;
  assign cc_oe    = strobe & ~wr_q & ~io_q;
  assign cc_we    = strobe & wr_q & ~io_q;
  assign cc_iord  = strobe & ~wr_q & io_q;
  assign cc_iowr  = strobe & wr_q & io_q;
  assign cpu_ack  = state_q == S_ACK;
  assign cpu_dout = cpu_ack ? dout_q : '0;
  assign busy     = state_q != S_IDLE;
  assign cpu_int  = int_q;
endmodule

// File: tb/tb_pcmcia_bus_ctrl.sv
// tb_pcmcia_bus_ctrl: directed and randomized transactions against a window/lane reference model
module tb_pcmcia_bus_ctrl;
  localparam int S = 2, T = 4, H = 1;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_wr = 1'b0, cpu_uds = 1'b0, cpu_lds = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic [15:0] cpu_din = '0, cc_din = '0;
  logic        card_present = 1'b0, cc_ireq = 1'b0, irq_clr = 1'b0;
  logic [15:0] cpu_dout, cc_dout;
  logic        cpu_ack, busy, cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2, cpu_int;
  logic [25:0] cc_addr;
  int          n_chk = 0, n_pass = 0;

  pcmcia_bus_ctrl #(.SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_ack(cpu_ack), .busy(busy), .card_present(card_present), .cc_addr(cc_addr),
    .cc_dout(cc_dout), .cc_din(cc_din), .cc_reg(cc_reg), .cc_oe(cc_oe), .cc_we(cc_we),
    .cc_iord(cc_iord), .cc_iowr(cc_iowr), .cc_ce1(cc_ce1), .cc_ce2(cc_ce2),
    .cc_ireq(cc_ireq), .irq_clr(irq_clr), .cpu_int(cpu_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One CPU transaction; the card answers with ccdin. extra_at re-pulses cpu_req at that
  // cycle, drop_at removes the card at that cycle (cycle 0 = cycle cpu_req is high).
  task automatic txn(input string tag, input logic [22:0] a, input logic wr, input logic uds,
                     input logic lds, input logic [15:0] din, input logic present,
                     input logic [15:0] ccdin, input int extra_at, input int drop_at);
    logic [23:0] ba;
    int          win, exp_lat, lat, strb_first, strb_cnt, act, bad, busy_cnt, post_bad;
    logic        hit, word;
    logic [7:0]  odd_b;
    logic [25:0] exp_addr, last_addr;
    logic [15:0] exp_dout, exp_ccd, got_dout;
    logic [3:0]  exp_strb, strb, strb_seen;
    ba       = {a, 1'b0};
    win      = (ba >= 24'h600000 && ba < 24'hA00000) ? 1 : (ba >= 24'hA00000 && ba < 24'hA20000) ? 2 :
               (ba >= 24'hA20000 && ba < 24'hA40000) ? 3 : 0;
    hit      = (win != 0) && present && (uds || lds);
    word     = uds && lds;
    exp_lat  = hit ? 1 + S + T + H : 1;
    odd_b    = word ? ccdin[15:8] : ccdin[7:0];
    exp_dout = !hit ? 16'hFFFF : wr ? 16'h0000 : {uds ? ccdin[7:0] : 8'hFF, lds ? odd_b : 8'hFF};
    exp_ccd  = wr ? {word ? din[7:0] : 8'h00, uds ? din[15:8] : din[7:0]} : 16'h0000;
    exp_addr = (win == 1) ? 26'(ba - 24'h600000) : 26'(ba[16:0]);
    exp_addr = exp_addr + 26'(lds && !uds);
    exp_strb = 4'b0001 << ((win == 3 ? 2 : 0) + (wr ? 1 : 0));
    @(negedge clk);
    cpu_addr = a; cpu_wr = wr; cpu_uds = uds; cpu_lds = lds; cpu_din = din;
    card_present = present; cc_din = ccdin; cpu_req = 1'b1;
    lat = 0; strb_first = 0; strb_cnt = 0; act = 0; bad = 0; busy_cnt = 0;
    strb_seen = '0; last_addr = '0; got_dout = '0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      cpu_req = (c == extra_at);
      if (c == extra_at) cpu_addr = a ^ 23'h1;
      if (c == drop_at) card_present = 1'b0;
      strb = {cc_iowr, cc_iord, cc_we, cc_oe};
      if (strb != 0) begin
        if (strb_first == 0) strb_first = c;
        strb_cnt++;
        strb_seen |= strb;
      end
      if (cc_ce1) begin
        act++;
        last_addr = cc_addr;
        if (cc_addr !== exp_addr || cc_ce2 !== word || cc_reg !== (win > 1) || cc_dout !== exp_ccd) bad++;
      end else if ({cc_addr, cc_dout, cc_reg, cc_ce2, strb} != 0) bad++;
      if (busy) busy_cnt++;
      if (cpu_ack) begin
        lat = c;
        got_dout = cpu_dout;
      end
    end
    cpu_req = 1'b0;
    post_bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack || busy) post_bad++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".cpu_dout"}, got_dout, exp_dout);
    chk({tag, ".busy_cycles"}, busy_cnt, exp_lat);
    chk({tag, ".card_cycles"}, act, hit ? S + T + H : 0);
    chk({tag, ".strobe_cycles"}, strb_cnt, hit ? T : 0);
    chk({tag, ".strobe_kind"}, strb_seen, hit ? exp_strb : 4'b0000);
    chk({tag, ".bus_errs"}, bad, 0);
    chk({tag, ".after_ack"}, post_bad, 0);
    if (hit) begin
      chk({tag, ".strobe_start"}, strb_first, 1 + S);
      chk({tag, ".cc_addr"}, last_addr, exp_addr);
    end
  endtask

  logic [22:0] ra;
  logic [1:0]  lanes;
  logic        rwr, rpres;
  int          r, acks;
  logic [22:0] bounds [8] = '{23'h2FFFFF, 23'h300000, 23'h4FFFFF, 23'h500000,
                              23'h50FFFF, 23'h510000, 23'h51FFFF, 23'h520000};

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ctl", {cpu_ack, busy, cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2, cpu_int}, 0);
    chk("rst.data", {cpu_dout, cc_dout}, 0);
    chk("rst.cc_addr", cc_addr, 0);
    reset_n = 1'b1;
    card_present = 1'b1;
    @(negedge clk);

    txn("attr_rd_word", 23'h500000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h3412, 0, 0);
    txn("io_wr_lds", 23'h510008, 1'b1, 1'b0, 1'b1, 16'h00AB, 1'b1, 16'h5555, 0, 0);
    txn("common_wr_word", 23'h309000, 1'b1, 1'b1, 1'b1, 16'hBEEF, 1'b1, 16'h0000, 0, 0);
    txn("common_rd_uds", 23'h380011, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h77C3, 0, 0);
    txn("miss_B00000", 23'h580000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h1234, 0, 0);
    txn("no_card", 23'h500000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h1234, 0, 0);
    txn("no_lanes", 23'h500000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234, 0, 0);
    txn("req_in_strobe", 23'h500010, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'hA55A, 4, 0);
    txn("card_removed", 23'h510020, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h00C7, 0, 3);
    for (int i = 0; i < 8; i++)
      txn("boundary", bounds[i], 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 16'($urandom), 0, 0);

    // Reset in the middle of the strobe phase
    card_present = 1'b1;
    @(negedge clk);
    cpu_addr = 23'h500000; cpu_wr = 1'b0; cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_req = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst.pre_oe", cc_oe, 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst.ctl", {cpu_ack, busy, cc_reg, cc_oe, cc_we, cc_iord, cc_iowr, cc_ce1, cc_ce2}, 0);
    chk("midrst.cc_addr", cc_addr, 0);
    reset_n = 1'b1;
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("midrst.no_ack", acks, 0);
    txn("after_rst", 23'h500002, 1'b1, 1'b1, 1'b1, 16'h1357, 1'b1, 16'h0000, 0, 0);

    // Interrupt latch
    card_present = 1'b1; cc_ireq = 1'b0; irq_clr = 1'b0;
    @(negedge clk);
    chk("irq.idle", cpu_int, 0);
    cc_ireq = 1'b1;
    @(negedge clk);
    chk("irq.set", cpu_int, 1);
    cc_ireq = 1'b0;
    @(negedge clk);
    cc_ireq = 1'b1; irq_clr = 1'b1;
    @(negedge clk);
    chk("irq.set_wins", cpu_int, 1);
    @(negedge clk);
    chk("irq.clr", cpu_int, 0);
    irq_clr = 1'b0; cc_ireq = 1'b0;
    @(negedge clk);
    cc_ireq = 1'b1;
    @(negedge clk);
    chk("irq.reset_again", cpu_int, 1);
    card_present = 1'b0;
    @(negedge clk);
    chk("irq.no_card", cpu_int, 0);
    cc_ireq = 1'b0;
    @(negedge clk);
    cc_ireq = 1'b1;
    @(negedge clk);
    chk("irq.no_card_edge", cpu_int, 0);
    cc_ireq = 1'b0; card_present = 1'b1;

    // Randomized traffic across all windows and outside them
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 4);
      ra = (r == 0) ? 23'h300000 + 23'($urandom_range(0, 32'h1FFFFF)) :
           (r == 1) ? 23'h500000 + 23'($urandom_range(0, 32'hFFFF)) :
           (r == 2) ? 23'h510000 + 23'($urandom_range(0, 32'hFFFF)) :
           (r == 3) ? 23'($urandom_range(0, 32'h2FFFFF)) :
                      23'h520000 + 23'($urandom_range(0, 32'h2DFFFF));
      lanes = 2'($urandom_range(0, 3));
      rpres = $urandom_range(0, 7) != 0;
      rwr = 1'($urandom_range(0, 1));
      if (r >= 3 || lanes == 2'b00 || !rpres) rwr = 1'b0;
      txn("rand", ra, rwr, lanes[1], lanes[0], 16'($urandom), rpres, 16'($urandom), 0,
          ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 6)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
